// File: rtl/caojiji_pkg.sv
// Shared types and frame tables for the caojiji sprite path.
// The state encoding matches state_out of the caojiji animation FSM.
package caojiji_pkg;

    typedef enum logic [1:0] {
        STAND  = 2'd0,
        ATTACK = 2'd1,
        MOVEL  = 2'd2,
        MOVER  = 2'd3
    } anim_state_t;

    localparam int NUM_FRAMES = 26;
    localparam int IDX_W      = $clog2(NUM_FRAMES);

    localparam logic [3:0]       FRAME_CNT  [4] = '{4'd8, 4'd9, 4'd5, 4'd4};
    localparam logic [IDX_W-1:0] FRAME_BASE [4] = '{5'd0, 5'd8, 5'd17, 5'd22};

    function automatic anim_state_t sanitise_state(input logic [7:0] st);
        return (st > 8'd3) ? STAND : anim_state_t'(st[1:0]);
    endfunction

    // Global frame number (base + clamped frame) for an FSM snapshot.
    function automatic logic [IDX_W-1:0] frame_index(input logic [7:0] st,
                                                     input logic [7:0] fr);
        anim_state_t s;
        logic [3:0]  f;
        s = sanitise_state(st);
        if (fr >= {4'd0, FRAME_CNT[s]}) f = FRAME_CNT[s] - 4'd1;
        else                            f = fr[3:0];
        return FRAME_BASE[s] + IDX_W'(f);
    endfunction

endpackage

// File: rtl/caojiji_anim_snapshot.sv
// Synchronises frame_clk and captures a sanitised animation snapshot on each
// rising edge, so the pixel pipeline never sees the FSM change mid-frame.
module caojiji_anim_snapshot
    import caojiji_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             frame_clk,
    input  logic [7:0]       anim_state,
    input  logic [7:0]       anim_frame,
    output logic [IDX_W-1:0] frame_idx
);

    logic fclk_meta;
    logic fclk_sync;
    logic fclk_prev;
    logic frame_rise;

    assign frame_rise = fclk_sync & ~fclk_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values and the two-flop synchroniser really is two stages.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fclk_meta <= 1'b0;
            fclk_sync <= 1'b0;
            fclk_prev <= 1'b0;
            frame_idx <= '0;
        end else begin
            fclk_meta <= frame_clk;
            fclk_sync <= fclk_meta;
            fclk_prev <= fclk_sync;
            if (frame_rise) frame_idx <= frame_index(anim_state, anim_frame);
        end
    end

endmodule

// File: rtl/caojiji_sprite_addr.sv
// Sprite ROM addressing: hit test -> address -> ROM return/transparency, 3 Clk latency.
// Define CAOJIJI_SPRITE_BBOX_EN to draw a solid outline on the sprite bounding box.
module caojiji_sprite_addr
    import caojiji_pkg::*;
#(
    parameter int                 SPR_W      = 64,
    parameter int                 SPR_H      = 64,
    parameter int                 ADDR_W     = 17,
    parameter int                 COLOR_W    = 4,
    parameter logic [COLOR_W-1:0] TRANSP_IDX = '0
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_clk,
    input  logic [7:0]         anim_state,
    input  logic [7:0]         anim_frame,
    input  logic [10:0]        char_x,
    input  logic [10:0]        char_y,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic               pix_valid,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic               sprite_on,
    output logic [COLOR_W-1:0] sprite_idx,
    output logic               out_valid
);

    localparam int LOG_W = $clog2(SPR_W);
    localparam int LOG_H = $clog2(SPR_H);

    logic [IDX_W-1:0] frame_idx;

    caojiji_anim_snapshot u_snapshot (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .anim_state (anim_state),
        .anim_frame (anim_frame),
        .frame_idx  (frame_idx)
    );

    // S1: sprite-relative coordinates; bit 11 set means left of / above the sprite.
    logic [11:0] rx;
    logic [11:0] ry;
    logic        in_x;
    logic        in_y;
    logic        hit;

    assign rx   = {2'b00, DrawX} - {char_x[10], char_x};
    assign ry   = {2'b00, DrawY} - {char_y[10], char_y};
    assign in_x = ~rx[11] & (rx < 12'(SPR_W));
    assign in_y = ~ry[11] & (ry < 12'(SPR_H));
    assign hit  = pix_valid & in_x & in_y;

    logic             s1_valid;
    logic             s1_hit;
    logic [LOG_W-1:0] s1_rx;
    logic [LOG_H-1:0] s1_ry;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid <= 1'b0;
            s1_hit   <= 1'b0;
            s1_rx    <= '0;
            s1_ry    <= '0;
        end else begin
            s1_valid <= pix_valid;
            s1_hit   <= hit;
            s1_rx    <= rx[LOG_W-1:0];
            s1_ry    <= ry[LOG_H-1:0];
        end
    end

    // S2: power-of-two sprite dimensions turn the address into shifted fields.
    logic [ADDR_W-1:0] addr_next;
    logic              s2_valid;
    logic              s2_hit;

    assign addr_next = (ADDR_W'(frame_idx) << (LOG_W + LOG_H))
                     | (ADDR_W'(s1_ry) << LOG_W)
                     | ADDR_W'(s1_rx);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s2_valid <= 1'b0;
            s2_hit   <= 1'b0;
            rom_addr <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_hit   <= s1_hit;
            if (s1_hit) rom_addr <= addr_next;
        end
    end

    // S3: rom_data for the S2 address arrives alongside these flops, so the
    // colour decision is combinational on the ROM return.
    logic s3_hit;
    logic opaque;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid <= 1'b0;
            s3_hit    <= 1'b0;
        end else begin
            out_valid <= s2_valid;
            s3_hit    <= s2_hit;
        end
    end

    assign opaque = (rom_data != TRANSP_IDX);

`ifdef CAOJIJI_SPRITE_BBOX_EN
    logic edge_px;
    logic s1_edge;
    logic s2_edge;
    logic s3_edge;

    assign edge_px = (rx[LOG_W-1:0] == '0) | (rx[LOG_W-1:0] == '1)
                   | (ry[LOG_H-1:0] == '0) | (ry[LOG_H-1:0] == '1);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_edge <= 1'b0;
            s2_edge <= 1'b0;
            s3_edge <= 1'b0;
        end else begin
            s1_edge <= edge_px;
            s2_edge <= s1_edge;
            s3_edge <= s2_edge;
        end
    end

    assign sprite_on  = s3_hit & (opaque | s3_edge);
    assign sprite_idx = !sprite_on ? '0 : (s3_edge ? '1 : rom_data);
`else
    assign sprite_on  = s3_hit & opaque;
    assign sprite_idx = sprite_on ? rom_data : '0;
`endif

endmodule
